// File: rtl/ram_bist_pkg.sv
// ---------------------------------------------------------------------------
// ram_bist_pkg
// Shared definitions for the RAM self-test controller:
//   - default address/data widths
//   - the controller state encoding
//   - the expected-pattern function used for both writing and comparing
// ---------------------------------------------------------------------------
package ram_bist_pkg;

  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 2;

  // Width of the state encoding, also used for the debug state output.
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_LAST  = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_t;

  // Expected word for an address: the address (zero-extended) XOR the seed.
  // The caller size-casts the result down to its data width, which gives the
  // truncation needed when the address is wider than the data word.
  function automatic logic [31:0] exp_word(input logic [31:0] addr,
                                           input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/ram_sp_sync.sv
// ---------------------------------------------------------------------------
// ram_sp_sync
// Single-port RAM with synchronous write and registered read.
//   i_clk    : clock, all updates on the rising edge
//   i_wr_en  : 1 = write i_wdata to mem[i_addr]; read data register holds
//              0 = o_rdata <= mem[i_addr]
//   i_addr   : word address
//   i_wdata  : write data
//   o_rdata  : registered read data (one cycle after the address)
// Contents are not reset; a self-test run always rewrites every word first.
// ---------------------------------------------------------------------------
module ram_sp_sync #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write and read are mutually exclusive per cycle, so there is no
  // read-during-write behaviour to define.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl
// Self-test controller for the board's single-port synchronous RAM. On an
// accepted start it writes exp(a) = a ^ seed to every address, reads every
// word back through the RAM's registered read port and counts miscompares.
//
// Ports:
//   clk_2           : system clock (rising edge)
//   reset_n         : asynchronous active-low reset
//   start           : level; accepted in IDLE or DONE
//   seed            : pattern seed, latched on accepted start
//   inj_en          : corrupt one write (inverted data), latched on start
//   inj_addr        : address to corrupt, latched on start
//   busy            : high in WRITE, READ, LAST
//   done            : high in DONE
//   pass            : valid while done, 1 when no miscompare
//   err_count       : miscompares in current/last run
//   first_fail_addr : lowest miscompared address, 0 if none
//   mem_addr        : RAM address driven
//   mem_wr_en       : RAM write enable driven
//   mem_wdata       : RAM write data driven (observability)
//   dbg_state       : current controller state (observability)
//
// Handshake: start is a plain level sampled on every rising edge; there is
// no ready. A start seen while busy is simply ignored, and a start held in
// DONE restarts immediately.
//
// Timing (start sampled at edge k, N words): writes on edges k+1..k+N,
// read captures on k+N+1..k+2N, final compare and done on edge k+2N+1.
// ---------------------------------------------------------------------------
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  inj_en,
  input  logic [ADDR_WIDTH-1:0] inj_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STATE_W-1:0]    dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  // Controller registers
  bist_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_seed;
  logic                  r_inj_en;
  logic [ADDR_WIDTH-1:0] r_inj_addr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [ADDR_WIDTH:0]   r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_fail;

  // Datapath wires
  logic [DATA_WIDTH-1:0] w_exp_wr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [ADDR_WIDTH-1:0] w_cmp_addr;
  logic [DATA_WIDTH-1:0] w_exp_cmp;
  logic                  w_cmp_en;
  logic                  w_mismatch;
  logic [ADDR_WIDTH:0]   w_err_next;

  // Write data follows the registered address; the injected address gets
  // the inverted pattern so the read-back compare is guaranteed to fail.
  assign w_exp_wr = DATA_WIDTH'(exp_word(32'(r_addr), 32'(r_seed)));
  assign w_wdata  = (r_inj_en && (r_addr == r_inj_addr)) ? ~w_exp_wr : w_exp_wr;

  ram_sp_sync #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (clk_2),
    .i_wr_en (r_wr_en),
    .i_addr  (r_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // The read data present during a READ cycle was captured for the previous
  // address, so the compare lags the address by one. The first READ cycle
  // (address 0) has nothing to compare yet. LAST holds the address at N-1
  // and compares that final word.
  always_comb begin
    w_cmp_en   = 1'b0;
    w_cmp_addr = r_addr;
    if (r_state == ST_READ) begin
      w_cmp_en   = (r_addr != '0);
      w_cmp_addr = r_addr - 1'b1;
    end else if (r_state == ST_LAST) begin
      w_cmp_en   = 1'b1;
      w_cmp_addr = r_addr;
    end
  end

  assign w_exp_cmp  = DATA_WIDTH'(exp_word(32'(w_cmp_addr), 32'(r_seed)));
  assign w_mismatch = w_cmp_en && (w_rdata != w_exp_cmp);
  // At most N miscompares per run, so err_count (ADDR_WIDTH+1 bits) never wraps.
  assign w_err_next = r_err_count + (ADDR_WIDTH + 1)'(w_mismatch);

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wr_en      <= 1'b0;
      r_seed       <= '0;
      r_inj_en     <= 1'b0;
      r_inj_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_first_fail <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_WRITE;
            r_addr       <= '0;
            r_wr_en      <= 1'b1;
            r_seed       <= seed;
            r_inj_en     <= inj_en;
            r_inj_addr   <= inj_addr;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_fail <= '0;
          end
        end

        ST_WRITE: begin
          if (r_addr == LAST_ADDR) begin
            r_state <= ST_READ;
            r_addr  <= '0;
            r_wr_en <= 1'b0;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end

        ST_READ: begin
          if (w_mismatch) begin
            r_err_count <= w_err_next;
            // Addresses are checked in ascending order, so the first
            // miscompare of a run is also the lowest failing address.
            if (r_err_count == '0) begin
              r_first_fail <= w_cmp_addr;
            end
          end
          if (r_addr == LAST_ADDR) begin
            r_state <= ST_LAST;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end

        ST_LAST: begin
          if (w_mismatch) begin
            r_err_count <= w_err_next;
            if (r_err_count == '0) begin
              r_first_fail <= w_cmp_addr;
            end
          end
          r_state <= ST_DONE;
          r_addr  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (w_err_next == '0);
        end

        default: begin
          r_state <= ST_IDLE;
          r_addr  <= '0;
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_fail_addr = r_first_fail;
  assign mem_addr        = r_addr;
  assign mem_wr_en       = r_wr_en;
  assign mem_wdata       = w_wdata;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_bist_ctrl
// Directed bench for ram_bist_ctrl (ADDR_WIDTH=2, DATA_WIDTH=2). Drivers push
// hand-computed write words and final results into queues; a monitor on the
// falling edge pops and compares whenever the DUT writes or raises done.
// ---------------------------------------------------------------------------
module tb_ram_bist_ctrl;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] seed;
  logic       inj_en;
  logic [1:0] inj_addr;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] first_fail_addr;
  logic [1:0] mem_addr;
  logic       mem_wr_en;
  logic [1:0] mem_wdata;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // {addr, wdata} per expected write; {pass, err_count, first_fail} per run
  logic [3:0] wr_q[$];
  logic [5:0] res_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk_2 = ~clk_2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ram_bist_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(2)) dut (
    .clk_2           (clk_2),
    .reset_n         (reset_n),
    .start           (start),
    .seed            (seed),
    .inj_en          (inj_en),
    .inj_addr        (inj_addr),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr),
    .mem_addr        (mem_addr),
    .mem_wr_en       (mem_wr_en),
    .mem_wdata       (mem_wdata),
    .dbg_state       (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_done = 1'b0;

  always @(negedge clk_2) begin
    logic [3:0] we;
    logic [5:0] re;
    if (reset_n && mem_wr_en) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 32'(wr_q.size()), 32'd1);
      end else begin
        we = wr_q.pop_front();
        check("write_addr_data", {28'd0, mem_addr, mem_wdata}, {28'd0, we});
      end
    end
    if (reset_n && done && !prev_done) begin
      if (res_q.size() == 0) begin
        check("unexpected_done", 32'(res_q.size()), 32'd1);
      end else begin
        re = res_q.pop_front();
        check("result_pass_err_ffa", {26'd0, pass, err_count, first_fail_addr}, {26'd0, re});
      end
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  // wr_tab packs the four expected write words, address 0 in bits [1:0].
  // mode 0: plain run; 1: change seed to 00 mid-run; 2: pulse start mid-WRITE
  task automatic push_writes(input logic [7:0] wr_tab);
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back({2'(i), wr_tab[2*i +: 2]});
    end
  endtask

  task automatic run_bist(input string name, input logic [1:0] s, input logic ie,
                          input logic [1:0] ia, input logic [7:0] wr_tab,
                          input logic p, input logic [2:0] ec, input logic [1:0] ffa,
                          input int mode);
    int n;
    push_writes(wr_tab);
    res_q.push_back({p, ec, ffa});
    @(negedge clk_2);
    seed = s; inj_en = ie; inj_addr = ia; start = 1'b1;
    @(posedge clk_2); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk_2); #1;
      n++;
      if (n == 4) check({name, "_busy"}, 32'(busy), 32'd1);
      if (mode == 1 && n == 3) seed = 2'b00;
      if (mode == 2 && n == 2) start = 1'b1;
      if (mode == 2 && n == 3) start = 1'b0;
    end
    check({name, "_done_latency"}, 32'(n), 32'd9);
    repeat (2) @(negedge clk_2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset_n = 1'b1; start = 1'b0; seed = 2'b00; inj_en = 1'b0; inj_addr = 2'b00;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk_2);
    #1;
    check("reset_outputs",
          {25'd0, busy, done, pass, err_count, mem_wr_en},
          32'd0);
    check("reset_addrs", {28'd0, first_fail_addr, mem_addr}, 32'd0);
    @(negedge clk_2);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_2);
      check("idle_quiet", {27'd0, busy, done, err_count[0], err_count[2:1] != 2'b00, mem_wr_en}, 32'd0);
    end

    // seed 01: writes 01,00,11,10
    run_bist("clean", 2'b01, 1'b0, 2'b00, 8'b10_11_00_01, 1'b1, 3'd0, 2'd0, 0);
    // seed 10, corrupt addr 2: writes 10,11,11,01 -> one miscompare at 2
    run_bist("inject", 2'b10, 1'b1, 2'b10, 8'b01_11_11_10, 1'b0, 3'd1, 2'd2, 0);
    // restart from DONE, seed 11 (writes 11,10,01,00); seed changed mid-run
    run_bist("restart", 2'b11, 1'b0, 2'b00, 8'b00_01_10_11, 1'b1, 3'd0, 2'd0, 1);
    // second start during WRITE ignored; seed 01 again
    run_bist("ign_start", 2'b01, 1'b0, 2'b00, 8'b10_11_00_01, 1'b1, 3'd0, 2'd0, 2);

    // abort during READ: seed 10 writes 10,11,00,01, then reset at edge k+6
    push_writes(8'b01_00_11_10);
    @(negedge clk_2);
    seed = 2'b10; inj_en = 1'b0; start = 1'b1;
    @(posedge clk_2); #1;
    start = 1'b0;
    n = 0;
    while (n < 6) begin
      @(posedge clk_2); #1;
      n++;
    end
    check("abort_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs",
          {25'd0, busy, done, pass, err_count, mem_wr_en},
          32'd0);
    check("abort_addrs", {28'd0, first_fail_addr, mem_addr}, 32'd0);
    @(negedge clk_2);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_2);
    // seed 00 after abort: writes 00,01,10,11
    run_bist("post_abort", 2'b00, 1'b0, 2'b00, 8'b11_10_01_00, 1'b1, 3'd0, 2'd0, 0);

    repeat (3) @(negedge clk_2);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
